// File: rtl/matrix_fire_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | matrix_fire_sequencer                                                        |
// | Row-major H-bridge matrix cell firing sequencer with drive/gap timing.       |
// | Optional continuous mode is enabled by defining SEQ_CONTINUOUS_EN.           |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module matrix_fire_sequencer #(
   parameter int NUM_ROWS = 10,
   parameter int NUM_COLS = 6,
   parameter int CNT_W    = 32
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               start_i,
   input  logic                               stop_i,
   input  logic                               mode_i,
   input  logic [CNT_W-1:0]                   cfg_ccr0_i,
   input  logic [CNT_W-1:0]                   cfg_ccr1_i,
   input  logic [7:0]                         cfg_row_limit_i,
   input  logic [7:0]                         cfg_col_limit_i,
   input  logic [NUM_ROWS+NUM_COLS-1:0]       cfg_inverter_select_i,
   input  logic [NUM_ROWS*NUM_COLS-1:0]       dot_data_i,
   output logic [2*(NUM_ROWS+NUM_COLS)-1:0]   driver_io_o,
   output logic                               busy_o,
   output logic                               update_cycle_complete_o,
   output logic [7:0]                         cur_row_o,
   output logic [7:0]                         cur_col_o
);
   localparam int               LINES   = NUM_ROWS + NUM_COLS;
   localparam int               CELLS   = NUM_ROWS * NUM_COLS;
   localparam logic [7:0]       ROW_MAX = 8'(NUM_ROWS - 1);
   localparam logic [7:0]       COL_MAX = 8'(NUM_COLS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRIVE = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   ccr0_q, gap_q;
   logic [7:0]         row_q, row_d, col_q, col_d;
   logic [7:0]         rlim_q, clim_q;
   logic [LINES-1:0]   inv_q;
   logic [CELLS-1:0]   dot_q;
   logic [2*LINES-1:0] drv_q, drv_d;

   logic               loading;
   logic [CNT_W-1:0]   ccr0_e, gap_e;
   logic [7:0]         rlim_e, clim_e;
   logic [LINES-1:0]   inv_e;
   logic [CELLS-1:0]   dot_e;
   logic [2*LINES-1:0] pat;
   logic [31:0]        cell_idx;
   logic               cell_on, last_col, last_cell, cont;

   // Live inputs are used during LOAD so the first cell sees the fresh snapshot.
   assign loading = (state_q == S_LOAD);
   assign ccr0_e  = loading ? cfg_ccr0_i : ccr0_q;
   assign gap_e   = loading ? ((cfg_ccr1_i > cfg_ccr0_i) ? (cfg_ccr1_i - cfg_ccr0_i) : CNT_ONE)
                            : gap_q;
   assign rlim_e  = loading ? ((cfg_row_limit_i > ROW_MAX) ? ROW_MAX : cfg_row_limit_i) : rlim_q;
   assign clim_e  = loading ? ((cfg_col_limit_i > COL_MAX) ? COL_MAX : cfg_col_limit_i) : clim_q;
   assign inv_e   = loading ? cfg_inverter_select_i : inv_q;
   assign dot_e   = loading ? dot_data_i : dot_q;

   assign last_col  = (col_q == clim_e);
   assign last_cell = last_col && (row_q == rlim_e);

`ifdef SEQ_CONTINUOUS_EN
   assign cont = mode_i;
`else
   logic unused_mode;
   assign unused_mode = mode_i;
   assign cont        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      col_d   = col_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_LOAD;
         end
         S_LOAD: begin
            row_d   = 8'd0;
            col_d   = 8'd0;
            cnt_d   = CNT_ONE;
            state_d = (ccr0_e == '0) ? S_GAP : S_DRIVE;
         end
         S_DRIVE: begin
            if (cnt_q == ccr0_e) begin
               cnt_d   = CNT_ONE;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == gap_e) begin
               cnt_d = CNT_ONE;
               if (last_cell) begin
                  state_d = S_DONE;
               end else begin
                  if (last_col) begin
                     row_d = row_q + 8'd1;
                     col_d = 8'd0;
                  end else begin
                     col_d = col_q + 8'd1;
                  end
                  state_d = (ccr0_e == '0) ? S_GAP : S_DRIVE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = cont ? S_LOAD : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (stop_i) state_d = S_IDLE;
   end

   // Row line is sourced HIGH, column line sunk LOW; an inverter bit swaps p/n.
   for (genvar k = 0; k < LINES; k++) begin : g_line
      logic on_k, hi_k;
      if (k < NUM_ROWS) begin : g_row
         assign on_k = (row_d == 8'(k));
         assign hi_k = ~inv_e[k];
      end else begin : g_col
         assign on_k = (col_d == 8'(k - NUM_ROWS));
         assign hi_k = inv_e[k];
      end
      assign pat[2*k+1] = on_k & hi_k;
      assign pat[2*k]   = on_k & ~hi_k;
   end

   assign cell_idx = 32'(row_d) * NUM_COLS + 32'(col_d);
   assign cell_on  = |(dot_e & ({{(CELLS-1){1'b0}}, 1'b1} << cell_idx));
   assign drv_d    = ((state_d == S_DRIVE) && cell_on) ? pat : '0;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         row_q   <= 8'd0;
         col_q   <= 8'd0;
         drv_q   <= '0;
         ccr0_q  <= '0;
         gap_q   <= '0;
         rlim_q  <= 8'd0;
         clim_q  <= 8'd0;
         inv_q   <= '0;
         dot_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         col_q   <= col_d;
         drv_q   <= drv_d;
         if (loading) begin
            ccr0_q <= ccr0_e;
            gap_q  <= gap_e;
            rlim_q <= rlim_e;
            clim_q <= clim_e;
            inv_q  <= inv_e;
            dot_q  <= dot_e;
         end
      end
   end

   assign driver_io_o             = drv_q;
   assign busy_o                  = (state_q != S_IDLE);
   assign update_cycle_complete_o = (state_q == S_DONE);
   assign cur_row_o               = row_q;
   assign cur_col_o               = col_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_fire_sequencer.sv
`default_nettype none
// Testbench for matrix_fire_sequencer: table-driven passes, randomized passes
// against a per-cycle reference trace, and stop/reset/continuous sequences.
module tb_matrix_fire_sequencer;
   localparam int NR = 10;
   localparam int NC = 6;
   localparam int L  = NR + NC;
   localparam int CW = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              stop  = 1'b0;
   logic              mode  = 1'b0;
   logic [CW-1:0]     ccr0  = '0;
   logic [CW-1:0]     ccr1  = '0;
   logic [7:0]        rlim  = '0;
   logic [7:0]        clim  = '0;
   logic [L-1:0]      inv   = '0;
   logic [NR*NC-1:0]  dot   = '0;
   logic [2*L-1:0]    drv;
   logic              busy, pulse;
   logic [7:0]        crow, ccol;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   matrix_fire_sequencer #(.NUM_ROWS(NR), .NUM_COLS(NC), .CNT_W(CW)) dut (
      .clock_i               (clock),
      .reset_i               (reset),
      .start_i               (start),
      .stop_i                (stop),
      .mode_i                (mode),
      .cfg_ccr0_i            (ccr0),
      .cfg_ccr1_i            (ccr1),
      .cfg_row_limit_i       (rlim),
      .cfg_col_limit_i       (clim),
      .cfg_inverter_select_i (inv),
      .dot_data_i            (dot),
      .driver_io_o           (drv),
      .busy_o                (busy),
      .update_cycle_complete_o(pulse),
      .cur_row_o             (crow),
      .cur_col_o             (ccol)
   );

   typedef struct {
      logic [2*L-1:0] drv;
      logic           busy;
      logic           pulse;
      int             row;
      int             col;
      bit             chk_rc;
   } exp_t;

   typedef struct {
      int               c0;
      int               c1;
      int               rl;
      int               cl;
      logic [L-1:0]     inv;
      logic [NR*NC-1:0] dot;
      int               exp_done;
      int               exp_drv;
      logic [2*L-1:0]   exp_or;
   } vec_t;

   exp_t  eq[$];
   vec_t  vt[8];
   int    pt[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Line r sourced (p=1), column line NR+c sunk (n=1); inversion swaps the pair.
   function automatic logic [2*L-1:0] cell_pattern(int r, int c, logic [L-1:0] iv);
      logic [2*L-1:0] v;
      v = '0;
      v[2*r+1]        = !iv[r];
      v[2*r]          = iv[r];
      v[2*(NR+c)+1]   = iv[NR+c];
      v[2*(NR+c)]     = !iv[NR+c];
      return v;
   endfunction

   task automatic push(input logic [2*L-1:0] d, input logic b, input logic p,
                       input int r, input int c, input bit k);
      exp_t e;
      e.drv = d; e.busy = b; e.pulse = p; e.row = r; e.col = c; e.chk_rc = k;
      eq.push_back(e);
   endtask

   // Expected trace: LOAD, then per cell ccr0 drive + gap clocks, then DONE and IDLE.
   task automatic build_model();
      int a0, a1, rl, cl, gap;
      a0  = int'(ccr0);
      a1  = int'(ccr1);
      rl  = (int'(rlim) >= NR) ? NR - 1 : int'(rlim);
      cl  = (int'(clim) >= NC) ? NC - 1 : int'(clim);
      gap = (a1 > a0) ? a1 - a0 : 1;
      eq.delete();
      push('0, 1'b1, 1'b0, 0, 0, 1'b0);
      for (int r = 0; r <= rl; r++) begin
         for (int c = 0; c <= cl; c++) begin
            for (int i = 0; i < a0; i++)
               push(dot[r*NC+c] ? cell_pattern(r, c, inv) : '0, 1'b1, 1'b0, r, c, 1'b1);
            for (int i = 0; i < gap; i++)
               push('0, 1'b1, 1'b0, r, c, 1'b1);
         end
      end
      push('0, 1'b1, 1'b1, 0, 0, 1'b0);
      push('0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic cmp_cycle(input int i);
      exp_t e;
      bit   ok;
      e  = eq[i];
      ok = (drv === e.drv) && (busy === e.busy) && (pulse === e.pulse);
      if (e.chk_rc) ok = ok && (crow === 8'(e.row)) && (ccol === 8'(e.col));
      for (int k = 0; k < L; k++) if (drv[2*k] && drv[2*k+1]) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         if (errors <= 40)
            $display("FAIL cycle %0d: got drv=%h busy=%b pulse=%b row=%0d col=%0d required drv=%h busy=%b pulse=%b row=%0d col=%0d",
                     i, drv, busy, pulse, crow, ccol, e.drv, e.busy, e.pulse, e.row, e.col);
      end
   endtask

   task automatic run_pass(input bit scramble, input bit rand_start,
                           output int done_off, output int drv_cyc, output logic [2*L-1:0] or_v);
      logic [63:0] tmp;
      build_model();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      done_off = -1;
      drv_cyc  = 0;
      or_v     = '0;
      for (int i = 0; i < eq.size(); i++) begin
         if (i > 0) begin
            @(posedge clock); #1;
            if (scramble) begin
               ccr0 = $urandom_range(0, 7);
               ccr1 = $urandom_range(0, 7);
               rlim = 8'($urandom);
               clim = 8'($urandom);
               inv  = L'($urandom);
               tmp  = {$urandom, $urandom};
               dot  = tmp[NR*NC-1:0];
            end
            if (rand_start) start = (i < eq.size() - 2) ? 1'($urandom % 2) : 1'b0;
         end
         @(negedge clock);
         cmp_cycle(i);
         if (pulse === 1'b1 && done_off < 0) done_off = i;
         if (drv != '0) drv_cyc++;
         or_v |= drv;
      end
   endtask

   task automatic set_cfg(input int c0, input int c1, input int rl, input int cl,
                          input logic [L-1:0] iv, input logic [NR*NC-1:0] dd);
      ccr0 = CW'(c0); ccr1 = CW'(c1); rlim = 8'(rl); clim = 8'(cl); inv = iv; dot = dd;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int               d_off, d_cyc, n;
      logic [2*L-1:0]   o_v;
      logic [63:0]      tmp;
      bit               found, seen;

      vt[0] = '{32, 128, 9, 5, {L{1'b0}}, {(NR*NC){1'b1}}, 7681, 1920, 32'h555AAAAA};
      vt[1] = '{4, 8, 9, 5, {L{1'b0}}, 60'h80, 481, 4, 32'h00400008};
      vt[2] = '{4, 8, 9, 5, 16'h0800, 60'h80, 481, 4, 32'h00800008};
      vt[3] = '{10, 5, 2, 1, {L{1'b0}}, {(NR*NC){1'b1}}, 67, 60, 32'h0050002A};
      vt[4] = '{0, 3, 9, 5, {L{1'b0}}, {(NR*NC){1'b1}}, 181, 0, 32'h0};
      vt[5] = '{1, 2, 200, 6, {L{1'b0}}, {(NR*NC){1'b1}}, 121, 60, 32'h555AAAAA};
      vt[6] = '{0, 0, 9, 5, {L{1'b0}}, {(NR*NC){1'b1}}, 61, 0, 32'h0};
      vt[7] = '{3, 3, 0, 0, {L{1'b0}}, {(NR*NC){1'b1}}, 5, 3, 32'h00100002};

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_drv", 64'(drv), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_pulse", 64'(pulse), 64'h0);
      check("reset_row", 64'(crow), 64'h0);
      check("reset_col", 64'(ccol), 64'h0);
      reset = 1'b0;

      for (int t = 0; t < 8; t++) begin
         set_cfg(vt[t].c0, vt[t].c1, vt[t].rl, vt[t].cl, vt[t].inv, vt[t].dot);
         run_pass(1'b1, 1'b0, d_off, d_cyc, o_v);
         check($sformatf("vec%0d_done_offset", t), 64'(d_off), 64'(vt[t].exp_done));
         check($sformatf("vec%0d_drive_cycles", t), 64'(d_cyc), 64'(vt[t].exp_drv));
         check($sformatf("vec%0d_lines_used", t), 64'(o_v), 64'(vt[t].exp_or));
      end

      for (int t = 0; t < 10; t++) begin
         tmp = {$urandom, $urandom};
         set_cfg($urandom_range(0, 5), $urandom_range(0, 8), $urandom_range(0, 11),
                 $urandom_range(0, 7), L'($urandom), tmp[NR*NC-1:0]);
         run_pass(1'b1, 1'b1, d_off, d_cyc, o_v);
      end

      // stop during DRIVE of cell (3,2)
      set_cfg(4, 6, 9, 5, {L{1'b0}}, {(NR*NC){1'b1}});
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clock);
         if (crow == 8'd3 && ccol == 8'd2 && drv != '0) found = 1'b1;
      end
      check("stop_reach_cell32", 64'(found), 64'h1);
      check("stop_cell32_drive", 64'(drv), 64'h01000080);
      stop = 1'b1;
      @(posedge clock); #1 stop = 1'b0;
      check("stop_busy", 64'(busy), 64'h0);
      check("stop_drv", 64'(drv), 64'h0);
      check("stop_pulse", 64'(pulse), 64'h0);
      seen = 1'b0;
      repeat (20) begin @(negedge clock); if (pulse || busy) seen = 1'b1; end
      check("stop_stays_idle", 64'(seen), 64'h0);

      // stop wins over simultaneous start
      @(posedge clock); #1 begin start = 1'b1; stop = 1'b1; end
      @(posedge clock); #1 begin start = 1'b0; stop = 1'b0; end
      @(negedge clock);
      check("stop_beats_start", 64'(busy), 64'h0);

      // asynchronous reset mid-DRIVE
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clock);
         if (crow == 8'd2 && drv != '0) found = 1'b1;
      end
      check("rst_reach_drive", 64'(found), 64'h1);
      #2 reset = 1'b1;
      #1;
      check("rst_async_outputs", {drv, busy, pulse, crow, ccol}, 64'h0);
      @(negedge clock) reset = 1'b0;
      seen = 1'b0;
      repeat (10) begin @(negedge clock); if (pulse || busy) seen = 1'b1; end
      check("rst_stays_idle", 64'(seen), 64'h0);

      // continuous mode
      set_cfg(2, 5, 1, 1, {L{1'b0}}, {(NR*NC){1'b1}});
      mode = 1'b1;
      pt.delete();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      for (int cyc = 0; cyc < 150; cyc++) begin
         @(negedge clock);
         if (pulse) pt.push_back(cyc);
         if (pt.size() == 3 && cyc == pt[2] + 5) mode = 1'b0;
      end
      n = pt.size();
`ifdef SEQ_CONTINUOUS_EN
      check("cont_pulse_count", 64'(n), 64'd4);
      for (int k = 1; k < 4; k++)
         check($sformatf("cont_interval%0d", k), 64'((n > k) ? pt[k] - pt[k-1] : -1), 64'd22);
`else
      check("oneshot_pulse_count", 64'(n), 64'd1);
`endif
      check("cont_end_idle", 64'(busy), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
